// File: rtl/cacheline_arbiter_if.sv
// Cache-side and burst-memory-side signal bundle for cacheline_arbiter.
// slave = arbiter view, master = caches/memory view.
interface cacheline_arbiter_if #(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned BEAT_W = 64
);
    localparam int unsigned LW = BEATS * BEAT_W;

    logic [31:0]       i_addr;
    logic              i_read;
    logic [LW-1:0]     i_rdata;
    logic              i_resp;

    logic [31:0]       d_addr;
    logic              d_read;
    logic              d_write;
    logic [LW-1:0]     d_wdata;
    logic [LW-1:0]     d_rdata;
    logic              d_resp;

    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [31:0]       bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
               bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output i_rdata, i_resp, d_rdata, d_resp,
               bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
               bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  i_rdata, i_resp, d_rdata, d_resp,
               bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/cacheline_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one burst memory port,
// one transaction at a time, alternating grants on contention.
module cacheline_arbiter #(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    cacheline_arbiter_if.slave bus
);
    localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_COLLECT, WR_BURST, DONE} state_t;
    typedef enum logic {inst_t, data_t} servicing_t;
    typedef logic [BEATS-1:0][BEAT_W-1:0] line_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     beat_cnt, beat_cnt_nxt;
    servicing_t        last_served, last_served_nxt;
    servicing_t        req_q, req_nxt;
    servicing_t        grant;
    logic              is_write_q, is_write_nxt;
    logic [31:0]       addr_q, addr_nxt;
    line_t             line_q, line_nxt;

    line_t             i_rdata_q, i_rdata_nxt;
    line_t             d_rdata_q, d_rdata_nxt;
    logic              i_resp_q, i_resp_nxt;
    logic              d_resp_q, d_resp_nxt;
    logic [31:0]       bmem_addr_q, bmem_addr_nxt;
    logic              bmem_read_q, bmem_read_nxt;
    logic              bmem_write_q, bmem_write_nxt;
    logic [BEAT_W-1:0] bmem_wdata_q, bmem_wdata_nxt;

    logic              i_req;
    logic              d_req;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    // State, transaction context and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            last_served  <= data_t;
            req_q        <= inst_t;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            line_q       <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
            bmem_addr_q  <= '0;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            bmem_wdata_q <= '0;
        end else begin
            state        <= state_nxt;
            beat_cnt     <= beat_cnt_nxt;
            last_served  <= last_served_nxt;
            req_q        <= req_nxt;
            is_write_q   <= is_write_nxt;
            addr_q       <= addr_nxt;
            line_q       <= line_nxt;
            i_rdata_q    <= i_rdata_nxt;
            d_rdata_q    <= d_rdata_nxt;
            i_resp_q     <= i_resp_nxt;
            d_resp_q     <= d_resp_nxt;
            bmem_addr_q  <= bmem_addr_nxt;
            bmem_read_q  <= bmem_read_nxt;
            bmem_write_q <= bmem_write_nxt;
            bmem_wdata_q <= bmem_wdata_nxt;
        end
    end

    // Next-state, grant and line-buffer update
    always_comb begin
        state_nxt       = state;
        beat_cnt_nxt    = beat_cnt;
        last_served_nxt = last_served;
        req_nxt         = req_q;
        is_write_nxt    = is_write_q;
        addr_nxt        = addr_q;
        line_nxt        = line_q;
        grant           = inst_t;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    if (i_req && d_req) begin
                        grant = (last_served == inst_t) ? data_t : inst_t;
                    end else begin
                        grant = i_req ? inst_t : data_t;
                    end
                    req_nxt      = grant;
                    is_write_nxt = (grant == data_t) && bus.d_write;
                    addr_nxt     = (grant == inst_t) ? {bus.i_addr[31:5], 5'd0}
                                                     : {bus.d_addr[31:5], 5'd0};
                    beat_cnt_nxt = '0;
                    if (is_write_nxt) begin
                        line_nxt  = bus.d_wdata;
                        state_nxt = WR_BURST;
                    end else begin
                        state_nxt = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (bus.bmem_ready) begin
                    state_nxt = RD_COLLECT;
                end
            end
            RD_COLLECT: begin
                // Beats tagged with another line address are not ours
                if (bus.bmem_rvalid && (bus.bmem_raddr == addr_q)) begin
                    line_nxt[beat_cnt] = bus.bmem_rdata;
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt_nxt = '0;
                        state_nxt    = DONE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            WR_BURST: begin
                if (bus.bmem_ready) begin
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt_nxt = '0;
                        state_nxt    = DONE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            DONE: begin
                last_served_nxt = req_q;
                state_nxt       = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        i_resp_nxt     = 1'b0;
        d_resp_nxt     = 1'b0;
        i_rdata_nxt    = i_rdata_q;
        d_rdata_nxt    = d_rdata_q;
        bmem_read_nxt  = 1'b0;
        bmem_write_nxt = 1'b0;
        bmem_addr_nxt  = '0;
        bmem_wdata_nxt = '0;

        case (state_nxt)
            RD_ISSUE: begin
                bmem_read_nxt = 1'b1;
                bmem_addr_nxt = addr_nxt;
            end
            WR_BURST: begin
                bmem_write_nxt = 1'b1;
                bmem_addr_nxt  = addr_nxt;
                bmem_wdata_nxt = line_nxt[beat_cnt_nxt];
            end
            DONE: begin
                if (req_nxt == inst_t) begin
                    i_resp_nxt = 1'b1;
                    if (!is_write_nxt) begin
                        i_rdata_nxt = line_nxt;
                    end
                end else begin
                    d_resp_nxt = 1'b1;
                    if (!is_write_nxt) begin
                        d_rdata_nxt = line_nxt;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.i_rdata    = i_rdata_q;
    assign bus.i_resp     = i_resp_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.d_resp     = d_resp_q;
    assign bus.bmem_addr  = bmem_addr_q;
    assign bus.bmem_read  = bmem_read_q;
    assign bus.bmem_write = bmem_write_q;
    assign bus.bmem_wdata = bmem_wdata_q;
endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: a burst-memory responder plus a
// scoreboard of expected completions and write beats.
module tb_cacheline_arbiter;
    localparam int unsigned BEATS  = 4;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned LW     = BEATS * BEAT_W;

    typedef struct {
        bit            port;   // 0 = icache, 1 = dcache
        logic [31:0]   addr;
        logic [LW-1:0] line;
        bit            wr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cacheline_arbiter_if #(.BEATS(BEATS), .BEAT_W(BEAT_W)) bus ();

    cacheline_arbiter #(.BEATS(BEATS), .BEAT_W(BEAT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_evt_cyc = 0;
    exp_t exp_q[$];
    logic [BEAT_W-1:0] wbeat_q[$];
    bit rd_pend = 1'b0;
    logic [31:0] rd_addr = '0;
    int rd_idx = 0;
    int wr_idx = 0;
    int stall_beat = -1;
    int stall_left = 0;
    bit stray_en = 1'b0;
    bit stray_done = 1'b0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] beat_val(input logic [31:0] a, input int k);
        logic [7:0] b;
        b = 8'((k + 1) * 17);
        return {8{b}} ^ {32'h0, a ^ 32'h0000_1040};
    endfunction

    function automatic logic [LW-1:0] exp_line(input logic [31:0] a);
        return {beat_val(a, 3), beat_val(a, 2), beat_val(a, 1), beat_val(a, 0)};
    endfunction

    // One clock: drive memory side, check invariants, consume completions
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        bus.bmem_rvalid = 1'b0;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;
        bus.bmem_ready  = 1'b1;
        if (rd_pend) begin
            bus.bmem_rvalid = 1'b1;
            if (stray_en && !stray_done && rd_idx == 1) begin
                bus.bmem_raddr = 32'h0000_3000;
                bus.bmem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
                stray_done     = 1'b1;
            end else begin
                bus.bmem_raddr = rd_addr;
                bus.bmem_rdata = beat_val(rd_addr, rd_idx);
                rd_idx++;
                if (rd_idx == BEATS) begin
                    rd_pend      = 1'b0;
                    last_evt_cyc = cyc;
                end
            end
        end
        if (bus.bmem_write && stall_left > 0 && wr_idx == stall_beat) begin
            bus.bmem_ready = 1'b0;
            stall_left--;
            if (wbeat_q.size() > 0) chk("wdata_stable", LW'(bus.bmem_wdata), LW'(wbeat_q[0]));
        end

        chk("rd_wr_excl", LW'(bus.bmem_read & bus.bmem_write), '0);
        chk("resp_excl", LW'(bus.i_resp & bus.d_resp), '0);
        if (!bus.bmem_read && !bus.bmem_write) chk("idle_wdata", LW'(bus.bmem_wdata), '0);

        if (bus.bmem_read && bus.bmem_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_read", LW'(bus.bmem_read), '0);
            end else begin
                chk("rd_addr", LW'(bus.bmem_addr), LW'(exp_q[0].addr));
                rd_pend    = 1'b1;
                rd_addr    = exp_q[0].addr;
                rd_idx     = 0;
                stray_done = 1'b0;
            end
        end

        if (bus.bmem_write && bus.bmem_ready) begin
            if (wbeat_q.size() == 0 || exp_q.size() == 0) begin
                chk("unexpected_write", LW'(bus.bmem_write), '0);
            end else begin
                chk("wr_addr", LW'(bus.bmem_addr), LW'(exp_q[0].addr));
                chk("wdata", LW'(bus.bmem_wdata), LW'(wbeat_q.pop_front()));
                wr_idx++;
                if (wr_idx == BEATS) begin
                    wr_idx       = 0;
                    last_evt_cyc = cyc;
                end
            end
        end

        if (bus.i_resp || bus.d_resp) begin
            if (exp_q.size() == 0) begin
                chk("spurious_resp", LW'({bus.i_resp, bus.d_resp}), '0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_port", LW'(bus.d_resp), LW'(e.port));
                chk("resp_latency", LW'(cyc), LW'(last_evt_cyc + 1));
                if (!e.wr) chk("rdata", bus.d_resp ? bus.d_rdata : bus.i_rdata, e.line);
            end
            if (bus.i_resp) bus.i_read = 1'b0;
            if (bus.d_resp) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, LW'(exp_q.size()), '0);
        exp_q.delete();
        wbeat_q.delete();
    endtask

    task automatic issue_i(input logic [31:0] a, input logic [LW-1:0] line);
        bus.i_addr = a;
        bus.i_read = 1'b1;
        exp_q.push_back('{port: 1'b0, addr: {a[31:5], 5'd0}, line: line, wr: 1'b0});
    endtask

    task automatic issue_dr(input logic [31:0] a);
        bus.d_addr = a;
        bus.d_read = 1'b1;
        exp_q.push_back('{port: 1'b1, addr: {a[31:5], 5'd0}, line: exp_line({a[31:5], 5'd0}), wr: 1'b0});
    endtask

    task automatic issue_dw(input logic [31:0] a, input logic [LW-1:0] w);
        logic [BEATS-1:0][BEAT_W-1:0] wb;
        wb          = w;
        bus.d_addr  = a;
        bus.d_wdata = w;
        bus.d_write = 1'b1;
        exp_q.push_back('{port: 1'b1, addr: {a[31:5], 5'd0}, line: '0, wr: 1'b1});
        wbeat_q.push_back(wb[0]);
        wbeat_q.push_back(wb[1]);
        wbeat_q.push_back(wb[2]);
        wbeat_q.push_back(wb[3]);
    endtask

    initial begin
        logic [LW-1:0] wline;
        logic [LW-1:0] line37;
        int n;
        line37 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        bus.i_addr = '0;  bus.i_read = 1'b0;
        bus.d_addr = '0;  bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
        bus.bmem_ready = 1'b0; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_i_resp", LW'(bus.i_resp), '0);
        chk("rst_d_resp", LW'(bus.d_resp), '0);
        chk("rst_bmem_read", LW'(bus.bmem_read), '0);
        chk("rst_bmem_write", LW'(bus.bmem_write), '0);
        chk("rst_bmem_addr", LW'(bus.bmem_addr), '0);
        chk("rst_i_rdata", bus.i_rdata, '0);
        chk("rst_d_rdata", bus.d_rdata, '0);
        rst_n = 1'b1;
        step();

        // Tie right after reset: icache first, then dcache; repeat tie -> icache first again
        issue_i(32'h0000_5008, exp_line(32'h0000_5000));
        issue_dr(32'h0000_6004);
        wait_done("tie1_done", 60);
        issue_i(32'h0000_5008, exp_line(32'h0000_5000));
        issue_dr(32'h0000_6004);
        wait_done("tie2_done", 60);

        // Single icache read with the documented beat pattern
        issue_i(32'h0000_1044, line37);
        wait_done("iread_done", 40);

        // Writeback with three stall cycles on beat 1
        wline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        stall_beat = 1;
        stall_left = 3;
        issue_dw(32'h0000_2000, wline);
        wait_done("write_done", 40);
        chk("stall_used", LW'(stall_left), '0);

        // d_read and d_write together behave as a write
        wline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        bus.d_read = 1'b1;
        issue_dw(32'h0000_2010, wline);
        wait_done("rw_done", 40);
        chk("d_rdata_hold", bus.d_rdata, exp_line(32'h0000_6000));

        // Stray beat for another line interleaved in a read
        stray_en = 1'b1;
        issue_i(32'h0000_1040, line37);
        wait_done("stray_done", 40);
        chk("stray_seen", LW'(stray_done), LW'(1));
        stray_en = 1'b0;

        // Reset after two captured beats
        issue_i(32'h0000_1040, line37);
        n = 0;
        while (!(rd_pend && rd_idx == 2) && n < 40) begin
            step();
            n++;
        end
        chk("two_beats_reached", LW'(rd_idx), LW'(2));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bmem_read", LW'(bus.bmem_read), '0);
        chk("mid_rst_i_resp", LW'(bus.i_resp), '0);
        chk("mid_rst_i_rdata", bus.i_rdata, '0);
        chk("mid_rst_d_rdata", bus.d_rdata, '0);
        exp_q.delete();
        bus.i_read = 1'b0;
        bus.bmem_rvalid = 1'b0;
        rd_pend = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_pend = 1'b1;
        rd_addr = 32'h0000_1040;
        rd_idx  = 2;
        repeat (3) step();
        chk("idle_beats_ignored", bus.i_rdata, '0);
        issue_dr(32'h0000_4000);
        wait_done("post_rst_read", 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
